// File: rtl/reg_seq_ctrl.sv
// Register-bank sequencer: runs LOAD_IMM / MOVE / SWAP requests as read/write cycle sequences.
// Optional macro REG_SEQ_SWAP_EN builds SWAP support (temp register B, RD_DST/WR_SRC states).
module reg_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_size,
    input  logic [2:0]  req_dst,
    input  logic [2:0]  req_src,
    input  logic [15:0] req_imm,
    output logic        done,
    output logic        err,
    output logic [2:0]  select_reg,
    output logic        size,
    output logic        select_high_low,
    output logic        select_data_h_reg,
    output logic        read_write,
    output logic [15:0] wr_data,
    input  logic [15:0] rd_data
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
`ifdef REG_SEQ_SWAP_EN
    localparam logic [1:0] OP_SWAP = 2'b10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_SRC = 3'd1,
`ifdef REG_SEQ_SWAP_EN
        ST_RD_DST = 3'd2,
        ST_WR_SRC = 3'd4,
`endif
        ST_WR_DST = 3'd3,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic [1:0]  op_r;
    logic        size_r;
    logic [2:0]  dst_r;
    logic [2:0]  src_r;
    logic [15:0] imm_r;
    logic [15:0] a_r;
`ifdef REG_SEQ_SWAP_EN
    logic [15:0] b_r;
`endif

    logic        rw_s;
    logic [2:0]  sel_s;
    logic        size_s;
    logic        hl_s;
    logic [15:0] wr_data_s;

    // 16-bit codes address a whole register; 8-bit codes pick a byte half of regs 0-3
    function automatic logic [3:0] decode_code(input logic sz, input logic [2:0] code);
        logic [3:0] res;
        if (sz) begin
            res = {code, 1'b0};
        end else begin
            res = {1'b0, code[1:0], code[2]};
        end
        return res;
    endfunction

    function automatic logic [15:0] fit_width(input logic sz, input logic [15:0] data);
        logic [15:0] res;
        if (sz) begin
            res = data;
        end else begin
            res = {8'h00, data[7:0]};
        end
        return res;
    endfunction

    // Next-state selection and request acceptance
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    case (req_op)
                        OP_LOAD: state_s = ST_WR_DST;
                        OP_MOVE: state_s = ST_RD_SRC;
`ifdef REG_SEQ_SWAP_EN
                        OP_SWAP: state_s = ST_RD_SRC;
`endif
                        default: state_s = ST_ERR;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_SRC: begin
`ifdef REG_SEQ_SWAP_EN
                if (op_r == OP_SWAP) begin
                    state_s = ST_RD_DST;
                end else begin
                    state_s = ST_WR_DST;
                end
`else
                state_s = ST_WR_DST;
`endif
            end
`ifdef REG_SEQ_SWAP_EN
            ST_RD_DST: state_s = ST_WR_DST;
            ST_WR_SRC: state_s = ST_DONE;
`endif
            ST_WR_DST: begin
`ifdef REG_SEQ_SWAP_EN
                if (op_r == OP_SWAP) begin
                    state_s = ST_WR_SRC;
                end else begin
                    state_s = ST_DONE;
                end
`else
                state_s = ST_DONE;
`endif
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Bank control decode; idle values apply outside the read and write states
    always_comb begin
        rw_s      = 1'b0;
        sel_s     = 3'd0;
        size_s    = 1'b1;
        hl_s      = 1'b0;
        wr_data_s = 16'h0000;
        case (state_r)
            ST_RD_SRC: begin
                {sel_s, hl_s} = decode_code(size_r, src_r);
                size_s        = size_r;
            end
`ifdef REG_SEQ_SWAP_EN
            ST_RD_DST: begin
                {sel_s, hl_s} = decode_code(size_r, dst_r);
                size_s        = size_r;
            end
            ST_WR_SRC: begin
                {sel_s, hl_s} = decode_code(size_r, src_r);
                size_s        = size_r;
                rw_s          = 1'b1;
                wr_data_s     = b_r;
            end
`endif
            ST_WR_DST: begin
                {sel_s, hl_s} = decode_code(size_r, dst_r);
                size_s        = size_r;
                rw_s          = 1'b1;
                if (op_r == OP_LOAD) begin
                    wr_data_s = fit_width(size_r, imm_r);
                end else begin
                    wr_data_s = a_r;
                end
            end
            default: begin
                rw_s = 1'b0;
            end
        endcase
    end

    // State, latched request and temp registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= 2'b00;
            size_r  <= 1'b0;
            dst_r   <= 3'd0;
            src_r   <= 3'd0;
            imm_r   <= 16'h0000;
            a_r     <= 16'h0000;
`ifdef REG_SEQ_SWAP_EN
            b_r     <= 16'h0000;
`endif
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                op_r   <= req_op;
                size_r <= req_size;
                dst_r  <= req_dst;
                src_r  <= req_src;
                imm_r  <= req_imm;
            end
            if (state_r == ST_RD_SRC) begin
                a_r <= fit_width(size_r, rd_data);
            end
`ifdef REG_SEQ_SWAP_EN
            if (state_r == ST_RD_DST) begin
                b_r <= fit_width(size_r, rd_data);
            end
`endif
        end
    end

    // Write strobe is gated by reset so a sequence cut mid-way never writes
    assign read_write        = rw_s & ~reset;
    assign select_reg        = sel_s;
    assign size              = size_s;
    assign select_high_low   = hl_s;
    assign wr_data           = wr_data_s;
    assign select_data_h_reg = 1'b0;
    assign req_ready         = (state_r == ST_IDLE);
    assign done              = (state_r == ST_DONE);
    assign err               = (state_r == ST_ERR);

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed bench for reg_seq_ctrl with a behavioural 8x16 register bank.
// SWAP expectations follow REG_SEQ_SWAP_EN.
module tb_reg_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_size;
    logic [2:0]  req_dst;
    logic [2:0]  req_src;
    logic [15:0] req_imm;
    logic        done;
    logic        err;
    logic [2:0]  select_reg;
    logic        size;
    logic        select_high_low;
    logic        select_data_h_reg;
    logic        read_write;
    logic [15:0] wr_data;
    logic [15:0] rd_data;

    logic [15:0] bank [8];

    int test_cnt = 0;
    int fail_cnt = 0;

    int          res_done_cyc;
    int          res_err_cyc;
    int          res_err_cnt;
    int          res_wr_cnt;
    logic [2:0]  res_wr_sel;
    logic        res_wr_hl;
    logic        res_wr_size;
    logic [15:0] res_wr_data;
    logic [2:0]  res_k1_sel;
    logic        res_k1_rw;

    reg_seq_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_size          (req_size),
        .req_dst           (req_dst),
        .req_src           (req_src),
        .req_imm           (req_imm),
        .done              (done),
        .err               (err),
        .select_reg        (select_reg),
        .size              (size),
        .select_high_low   (select_high_low),
        .select_data_h_reg (select_data_h_reg),
        .read_write        (read_write),
        .wr_data           (wr_data),
        .rd_data           (rd_data)
    );

    always #5 clk = ~clk;

    // Bank write port: byte writes touch only the selected half
    always_ff @(posedge clk) begin
        if (read_write) begin
            if (size) begin
                bank[select_reg] <= wr_data;
            end else if (select_high_low) begin
                bank[select_reg][15:8] <= wr_data[7:0];
            end else begin
                bank[select_reg][7:0] <= wr_data[7:0];
            end
        end
    end

    // Bank read port, combinational
    always_comb begin
        if (size) begin
            rd_data = bank[select_reg];
        end else if (select_high_low) begin
            rd_data = {8'h00, bank[select_reg][15:8]};
        end else begin
            rd_data = {8'h00, bank[select_reg][7:0]};
        end
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_ready();
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) check_value("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // Issue one request, scramble the inputs after acceptance, then trace until done/err
    task automatic run_op(input logic [1:0] op, input logic sz, input logic [2:0] dst,
                          input logic [2:0] src, input logic [15:0] imm);
        wait_ready();
        req_valid = 1'b1;
        req_op    = op;
        req_size  = sz;
        req_dst   = dst;
        req_src   = src;
        req_imm   = imm;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_size  = ~sz;
        req_dst   = ~dst;
        req_src   = ~src;
        req_imm   = ~imm;
        res_done_cyc = 0;
        res_err_cyc  = 0;
        res_err_cnt  = 0;
        res_wr_cnt   = 0;
        res_wr_sel   = 3'd0;
        res_wr_hl    = 1'b0;
        res_wr_size  = 1'b0;
        res_wr_data  = 16'h0000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                res_k1_sel = select_reg;
                res_k1_rw  = read_write;
            end
            if (read_write) begin
                res_wr_cnt++;
                if (res_wr_cnt == 1) begin
                    res_wr_sel  = select_reg;
                    res_wr_hl   = select_high_low;
                    res_wr_size = size;
                    res_wr_data = wr_data;
                end
            end
            if (err) begin
                res_err_cnt++;
                if (res_err_cyc == 0) res_err_cyc = k;
            end
            if (done && res_done_cyc == 0) res_done_cyc = k;
            if (done || err) break;
        end
        if (!(done || err)) check_value("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d1;
        int d2;
        int dcnt;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_size  = 1'b0;
        req_dst   = 3'd0;
        req_src   = 3'd0;
        req_imm   = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_value("rst_ready", {31'd0, req_ready}, 32'd1);
        check_value("rst_done", {31'd0, done}, 32'd0);
        check_value("rst_err", {31'd0, err}, 32'd0);
        check_value("rst_rw", {31'd0, read_write}, 32'd0);
        check_value("rst_sel", {29'd0, select_reg}, 32'd0);
        check_value("rst_size", {31'd0, size}, 32'd1);
        check_value("rst_hl", {31'd0, select_high_low}, 32'd0);
        check_value("rst_wrdata", {16'd0, wr_data}, 32'd0);
        check_value("rst_dh", {31'd0, select_data_h_reg}, 32'd0);

        // LOAD_IMM 16-bit into reg3
        run_op(2'b00, 1'b1, 3'd3, 3'd0, 16'hBEEF);
        check_value("ld16_done_cyc", res_done_cyc, 32'd2);
        check_value("ld16_wr_cnt", res_wr_cnt, 32'd1);
        check_value("ld16_wr_sel", {29'd0, res_wr_sel}, 32'd3);
        check_value("ld16_wr_data", {16'd0, res_wr_data}, 32'h0000BEEF);
        check_value("ld16_bank3", {16'd0, bank[3]}, 32'h0000BEEF);

        // LOAD_IMM 8-bit into high byte of reg1
        run_op(2'b00, 1'b1, 3'd1, 3'd0, 16'h5566);
        run_op(2'b00, 1'b0, 3'b101, 3'd0, 16'h12A5);
        check_value("ld8_wr_sel", {29'd0, res_wr_sel}, 32'd1);
        check_value("ld8_wr_hl", {31'd0, res_wr_hl}, 32'd1);
        check_value("ld8_wr_size", {31'd0, res_wr_size}, 32'd0);
        check_value("ld8_wr_data", {16'd0, res_wr_data}, 32'h000000A5);
        check_value("ld8_bank1", {16'd0, bank[1]}, 32'h0000A566);

        // MOVE reg2 -> reg6
        run_op(2'b00, 1'b1, 3'd2, 3'd0, 16'h1234);
        run_op(2'b00, 1'b1, 3'd6, 3'd0, 16'h0000);
        run_op(2'b01, 1'b1, 3'd6, 3'd2, 16'h0000);
        check_value("mv_done_cyc", res_done_cyc, 32'd3);
        check_value("mv_rd_sel", {29'd0, res_k1_sel}, 32'd2);
        check_value("mv_rd_rw", {31'd0, res_k1_rw}, 32'd0);
        check_value("mv_wr_cnt", res_wr_cnt, 32'd1);
        check_value("mv_wr_sel", {29'd0, res_wr_sel}, 32'd6);
        check_value("mv_wr_data", {16'd0, res_wr_data}, 32'h00001234);
        check_value("mv_bank6", {16'd0, bank[6]}, 32'h00001234);

        // MOVE with src == dst leaves the value intact
        run_op(2'b01, 1'b1, 3'd2, 3'd2, 16'h0000);
        check_value("mvsame_done_cyc", res_done_cyc, 32'd3);
        check_value("mvsame_bank2", {16'd0, bank[2]}, 32'h00001234);

        // 8-bit SWAP of reg0 halves
        run_op(2'b00, 1'b1, 3'd0, 3'd0, 16'hAB12);
        run_op(2'b10, 1'b0, 3'b100, 3'b000, 16'h0000);
`ifdef REG_SEQ_SWAP_EN
        check_value("swap_done_cyc", res_done_cyc, 32'd5);
        check_value("swap_wr_cnt", res_wr_cnt, 32'd2);
        check_value("swap_err_cnt", res_err_cnt, 32'd0);
        check_value("swap_bank0", {16'd0, bank[0]}, 32'h000012AB);
`else
        check_value("swap_err_cyc", res_err_cyc, 32'd1);
        check_value("swap_done_cyc", res_done_cyc, 32'd0);
        check_value("swap_wr_cnt", res_wr_cnt, 32'd0);
        check_value("swap_bank0", {16'd0, bank[0]}, 32'h0000AB12);
`endif

        // Illegal op
        run_op(2'b11, 1'b1, 3'd4, 3'd5, 16'hFFFF);
        check_value("ill_err_cyc", res_err_cyc, 32'd1);
        check_value("ill_err_cnt", res_err_cnt, 32'd1);
        check_value("ill_done_cyc", res_done_cyc, 32'd0);
        check_value("ill_wr_cnt", res_wr_cnt, 32'd0);
        @(negedge clk);
        check_value("ill_ready_next", {31'd0, req_ready}, 32'd1);
        check_value("ill_err_next", {31'd0, err}, 32'd0);

        // Reset during WR_DST of a MOVE
        run_op(2'b00, 1'b1, 3'd5, 3'd0, 16'h0F0F);
        wait_ready();
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_size  = 1'b1;
        req_src   = 3'd2;
        req_dst   = 3'd5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_value("rstmid_rw_before", {31'd0, read_write}, 32'd1);
        reset = 1'b1;
        #1;
        check_value("rstmid_rw_forced", {31'd0, read_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_value("rstmid_ready", {31'd0, req_ready}, 32'd1);
        check_value("rstmid_done", {31'd0, done}, 32'd0);
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_value("rstmid_no_done", dcnt, 32'd0);
        check_value("rstmid_bank5", {16'd0, bank[5]}, 32'h00000F0F);

        // req_valid held high is re-accepted on the first IDLE cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_size  = 1'b1;
        req_dst   = 3'd7;
        req_imm   = 16'h7777;
        d1 = 0;
        d2 = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
        end
        req_valid = 1'b0;
        check_value("hold_first_done", d1, 32'd2);
        check_value("hold_second_done", d2, 32'd5);
        check_value("hold_bank7", {16'd0, bank[7]}, 32'h00007777);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/reg_seq_ctrl.md
REG_SEQ_CTRL -- requirements
Module: reg_seq_ctrl

Interface
REQ-001 The block SHALL use one clock `clk`; `reset` SHALL be synchronous and active-high.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  reset  in  1  sync active-high reset
  req_valid  in  1  request present
  req_ready  out  1  block can accept a request
  req_op  in  2  00 LOAD_IMM, 01 MOVE, 10 SWAP, 11 illegal
  req_size  in  1  1 = 16-bit, 0 = 8-bit
  req_dst  in  3  destination code
  req_src  in  3  source code (MOVE/SWAP)
  req_imm  in  16  immediate (LOAD_IMM; low byte used when req_size=0)
  done  out  1  one-cycle completion pulse
  err  out  1  one-cycle illegal-op pulse
  select_reg  out  3  register bank index
  size  out  1  register bank access width
  select_high_low  out  1  byte half (1 = high)
  select_data_h_reg  out  1  high-byte data source select, driven 0
  read_write  out  1  0 = read, 1 = write
  wr_data  out  16  register bank write data (byte in [7:0] when size=0)
  rd_data  in  16  register bank read data; combinational, valid in the same cycle (byte in [7:0])

Function
REQ-003 Handshake: a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE.
  - All req_* fields SHALL be latched at acceptance.
  - Inputs changing afterwards SHALL have no effect.
REQ-004 Code decode:
  - 16-bit: select_reg = code, select_high_low = 0.
  - 8-bit: select_reg = {0, code[1:0]}, select_high_low = code[2].
REQ-005 States SHALL be IDLE, RD_SRC, RD_DST, WR_DST, WR_SRC, DONE, ERR.
REQ-006 LOAD_IMM: IDLE -> WR_DST -> DONE -> IDLE.
  - In WR_DST: read_write=1, wr_data = imm (8-bit: {8'h00, imm[7:0]}).
REQ-007 MOVE: IDLE -> RD_SRC -> WR_DST -> DONE -> IDLE.
  - In RD_SRC: read_write=0 at the src code; rd_data SHALL be captured into temp register A at the closing edge.
  - In WR_DST: wr_data = A.
REQ-008 SWAP: IDLE -> RD_SRC -> RD_DST -> WR_DST -> WR_SRC -> DONE -> IDLE.
  - Src is captured into A, dst into B.
  - In WR_DST: wr_data = A. In WR_SRC: wr_data = B.
REQ-009 Illegal op (11): IDLE -> ERR -> IDLE.
  - err=1 for the ERR cycle only.
  - No write cycle SHALL be issued.
REQ-010 done SHALL be 1 only in DONE; req_ready SHALL be 0 in DONE.
  - Accept-to-done latency: LOAD_IMM 2, MOVE 3, SWAP 5 cycles.
REQ-011 Outside RD_* and WR_* states, the bank control outputs SHALL be: read_write=0, select_reg=0, size=1, select_high_low=0, wr_data=0.
REQ-012 read_write SHALL be 1 only in WR_DST and WR_SRC, exactly one cycle each.
REQ-013 Boundary cases:
  - src == dst for MOVE or SWAP SHALL execute normally; the register value is unchanged.
  - 8-bit SWAP of the high and low halves of the same register (e.g. codes 3'b000/3'b100) SHALL exchange the bytes.
  - 8-bit writes SHALL NOT alter the other byte; the bank is responsible for this.
  - req_valid held high SHALL be accepted again on the first IDLE cycle after DONE or ERR.

Reset
REQ-014 While reset=1, read_write SHALL be forced 0 combinationally, so no bank write occurs in a reset cycle even mid-sequence.
REQ-015 After a reset edge the block SHALL hold these values:
  - state = IDLE
  - A = B = 0
  - latched request = 0
  - done = err = 0
  - req_ready = 1
  - bank outputs at the REQ-011 values
REQ-016 A request in flight during reset SHALL be abandoned without a done pulse.

Configuration
REQ-017 Macro REG_SEQ_SWAP_EN SHALL control SWAP support.
  - Defined: op 10 executes per REQ-008 and register B exists.
  - Undefined: op 10 is illegal per REQ-009 and register B and states RD_DST/WR_SRC are not built.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - LOAD_IMM size=1, dst=3, imm=16'hBEEF -> single write cycle select_reg=3, wr_data=BEEF; done 2 cycles after accept; bank reg3 reads BEEF.
  - LOAD_IMM size=0, dst=3'b101, imm=16'h12A5 -> write select_reg=1, select_high_low=1, wr_data=00A5; bank reg1 low byte unchanged.
  - reg2=1234, MOVE size=1, src=2, dst=6 -> read reg2 then write reg6 = 1234; done at cycle 3.
  - reg0=AB12, SWAP size=0, src=3'b000, dst=3'b100 (REG_SEQ_SWAP_EN defined) -> reg0=12AB; done at cycle 5. Same stimulus with the macro undefined -> err pulse and no write.
  - op=11 -> err=1 for one cycle; read_write stays 0; req_ready back to 1 the next cycle.
  - reset asserted during WR_DST of MOVE -> no write in that cycle; IDLE next cycle; no done pulse; req_ready=1.
